imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage of the RISC-V core. It decodes all base immediate formats (I, S, B, U, J, plus R with no immediate) and sign-extends the result to XLEN. It flags illegal opcodes. Results are buffered in a small FIFO with valid/ready handshakes on both sides, so fetch and execute can stall independently.

---
 rtl/imm_pkg.sv | 33 +++
 rtl/imm_decode.sv | 86 ++++++++
 rtl/imm_gen_pipe.sv | 102 ++++++++++
 tb/tb_imm_gen_pipe.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the RISC-V immediate generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imm_pkg;

    // Immediate format of a decoded instruction; FMT_ILL marks unknown opcodes.
    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    // The buffer entry is {imm, fmt, illegal}. Its imm field is XLEN wide,
    // so each user declares entry_t locally against its own XLEN.

endpackage

// File: rtl/imm_decode.sv
// Combinational decode of a 32-bit instruction into a sign-extended immediate and format.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic        is_shift;
    logic [31:0] i_imm;
    logic [31:0] raw;

    assign opc      = inst[6:0];
    assign funct3   = inst[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign i_imm    = {{20{inst[31]}}, inst[31:20]};

    // Every format is first assembled as a 32-bit value already sign-extended
    // to bit 31; shift amounts keep bit 31 clear so the final widening leaves them positive.
    always_comb begin
        fmt = FMT_ILL;
        raw = 32'd0;
        case (opc)
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                fmt = FMT_I;
                raw = i_imm;
            end
            OP_IMM: begin
                fmt = FMT_I;
                if (is_shift)
                    raw = RV64 ? {26'd0, inst[25:20]} : {27'd0, inst[24:20]};
                else
                    raw = i_imm;
            end
            OP_IMM32: begin
                if (RV64) begin
                    fmt = FMT_I;
                    raw = is_shift ? {27'd0, inst[24:20]} : i_imm;
                end
            end
            OP_STORE: begin
                fmt = FMT_S;
                raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                fmt = FMT_B;
                raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt = FMT_U;
                raw = {inst[31:12], 12'd0};
            end
            OP_JAL: begin
                fmt = FMT_J;
                raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OP_REG: begin
                fmt = FMT_R;
            end
            OP_REG32: begin
                if (RV64)
                    fmt = FMT_R;
            end
            default: begin
                fmt = FMT_ILL;
            end
        endcase
    end

    // Widen to XLEN by replicating bit 31.
    always_comb begin
        imm     = XLEN'($signed(raw));
        illegal = (fmt == FMT_ILL);
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator: decodes each accepted instruction and queues {imm, fmt, illegal} in a DEPTH-entry FIFO.
// Latency: 1 cycle from acceptance to out_valid when the buffer is empty.
// Backpressure: in_ready derives from the registered count only; a full buffer refuses pushes even on a pop cycle.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_out,
    output fmt_e            imm_fmt,
    output logic            illegal
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_ill;
    entry_t          dec_entry;

    // Storage is always two slots; with DEPTH=1 the pointers never leave slot 0.
    entry_t          mem [2];
    entry_t          last_q;
    entry_t          head;
    logic [1:0]      count;
    logic [1:0]      count_nxt;
    logic            wr_ptr;
    logic            rd_ptr;
    logic            in_ready_q;
    logic            push;
    logic            pop;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .inst    (inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    function automatic logic ptr_inc(input logic p);
        return (DEPTH == 1) ? 1'b0 : ~p;
    endfunction

    assign dec_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_ill};
    assign out_valid = (count != 2'd0);
    assign in_ready  = in_ready_q;
    assign push      = in_valid && in_ready_q;
    assign pop       = out_valid && out_ready;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt = count + 2'(push) - 2'(pop);
    end

    // Control state: count, pointers, registered ready and the last popped entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            in_ready_q <= 1'b1;
            last_q     <= '{imm: '0, fmt: FMT_R, illegal: 1'b0};
        end else begin
            count      <= count_nxt;
            in_ready_q <= (count_nxt < 2'(DEPTH));
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
                last_q <= mem[rd_ptr];
            end
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_ptr] <= dec_entry;
    end

    // An empty buffer keeps presenting the most recently popped entry.
    always_comb begin
        head = out_valid ? mem[rd_ptr] : last_q;
    end

    assign imm_out = head.imm;
    assign imm_fmt = head.fmt;
    assign illegal = head.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=32/DEPTH=2, XLEN=64/DEPTH=2, XLEN=32/DEPTH=1).
// All instances share stimulus; each test checks the instance relevant to it.
// Inputs change and outputs are sampled on the falling edge.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] inst = 32'd0;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32;
    fmt_e        fmt32;
    logic        rdy64, vld64, ill64;
    logic [63:0] imm64;
    fmt_e        fmt64;
    logic        rdy1, vld1, ill1;
    logic [31:0] imm1;
    fmt_e        fmt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .inst(inst),
        .out_valid(vld32), .out_ready(out_ready), .imm_out(imm32), .imm_fmt(fmt32), .illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .inst(inst),
        .out_valid(vld64), .out_ready(out_ready), .imm_out(imm64), .imm_fmt(fmt64), .illegal(ill64)
    );

    imm_gen_pipe #(.XLEN(32), .DEPTH(1)) dut_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .inst(inst),
        .out_valid(vld1), .out_ready(out_ready), .imm_out(imm1), .imm_fmt(fmt1), .illegal(ill1)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inst = 32'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (vld32 !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", vld32); end
        checks++; if (imm32 !== 32'd0) begin errors++; $display("FAIL reset_imm got %h exp 0", imm32); end
        checks++; if (fmt32 !== FMT_R) begin errors++; $display("FAIL reset_fmt got %0d exp %0d", fmt32, FMT_R); end
        checks++; if (ill32 !== 1'b0) begin errors++; $display("FAIL reset_ill got %b exp 0", ill32); end
        checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", rdy32); end
    endtask

    task automatic test_addi();
        do_reset();
        in_valid = 1'b1; inst = 32'hFFF00093; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (vld32 !== 1'b1) begin errors++; $display("FAIL addi_vld got %b exp 1", vld32); end
        checks++; if (imm32 !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm32 got %h exp ffffffff", imm32); end
        checks++; if (fmt32 !== FMT_I) begin errors++; $display("FAIL addi_fmt got %0d exp %0d", fmt32, FMT_I); end
        checks++; if (imm64 !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL addi_imm64 got %h exp ffffffffffffffff", imm64); end
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL d1_rdy_full got %b exp 0", rdy1); end
        @(negedge clk);
        checks++; if (vld32 !== 1'b0) begin errors++; $display("FAIL addi_drain_vld got %b exp 0", vld32); end
        checks++; if (imm32 !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_hold_imm got %h exp ffffffff", imm32); end
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL d1_rdy_empty got %b exp 1", rdy1); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; inst = 32'hFE112E23;
        @(negedge clk);
        inst = 32'h00000863;
        checks++; if (imm32 !== 32'hFFFFFFFC || fmt32 !== FMT_S) begin errors++; $display("FAIL b2b_sw got %h/%0d exp fffffffc/%0d", imm32, fmt32, FMT_S); end
        @(negedge clk);
        inst = 32'h123452B7;
        checks++; if (imm32 !== 32'h00000010 || fmt32 !== FMT_B) begin errors++; $display("FAIL b2b_beq got %h/%0d exp 00000010/%0d", imm32, fmt32, FMT_B); end
        @(negedge clk);
        inst = 32'hFF9FF06F;
        checks++; if (imm32 !== 32'h12345000 || fmt32 !== FMT_U) begin errors++; $display("FAIL b2b_lui got %h/%0d exp 12345000/%0d", imm32, fmt32, FMT_U); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (imm32 !== 32'hFFFFFFF8 || fmt32 !== FMT_J) begin errors++; $display("FAIL b2b_jal got %h/%0d exp fffffff8/%0d", imm32, fmt32, FMT_J); end
        checks++; if (vld32 !== 1'b1) begin errors++; $display("FAIL b2b_vld got %b exp 1", vld32); end
        @(negedge clk);
        checks++; if (vld32 !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", vld32); end
    endtask

    task automatic test_shift();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; inst = 32'h4030D093;
        @(negedge clk);
        inst = 32'h02009093;
        checks++; if (imm32 !== 32'h00000003) begin errors++; $display("FAIL srai_imm32 got %h exp 00000003", imm32); end
        checks++; if (imm64 !== 64'h3) begin errors++; $display("FAIL srai_imm64 got %h exp 3", imm64); end
        @(negedge clk);
        inst = 32'hFFF0009B;
        checks++; if (imm64 !== 64'h20) begin errors++; $display("FAIL slli32_rv64 got %h exp 20", imm64); end
        checks++; if (imm32 !== 32'h0) begin errors++; $display("FAIL slli32_rv32 got %h exp 0", imm32); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (imm64 !== 64'hFFFFFFFFFFFFFFFF || fmt64 !== FMT_I) begin errors++; $display("FAIL addiw_rv64 got %h/%0d exp all-ones/%0d", imm64, fmt64, FMT_I); end
        checks++; if (ill32 !== 1'b1 || fmt32 !== FMT_ILL || imm32 !== 32'd0) begin errors++; $display("FAIL addiw_rv32 got %b/%0d/%h exp 1/%0d/0", ill32, fmt32, imm32, FMT_ILL); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; inst = 32'hFE112E23;
        @(negedge clk);
        inst = 32'h00000863;
        checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL bp_rdy_one got %b exp 1", rdy32); end
        @(negedge clk);
        inst = 32'h123452B7;
        checks++; if (rdy32 !== 1'b0) begin errors++; $display("FAIL bp_rdy_full got %b exp 0", rdy32); end
        checks++; if (imm32 !== 32'hFFFFFFFC) begin errors++; $display("FAIL bp_head_a got %h exp fffffffc", imm32); end
        @(negedge clk);
        checks++; if (rdy32 !== 1'b0) begin errors++; $display("FAIL bp_c_held got %b exp 0", rdy32); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (imm32 !== 32'h00000010) begin errors++; $display("FAIL bp_head_b got %h exp 00000010", imm32); end
        checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL bp_rdy_rise got %b exp 1", rdy32); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (imm32 !== 32'h12345000 || vld32 !== 1'b1) begin errors++; $display("FAIL bp_head_c got %h/%b exp 12345000/1", imm32, vld32); end
        @(negedge clk);
        checks++; if (vld32 !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", vld32); end
    endtask

    task automatic test_illegal();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; inst = 32'h0000007F;
        @(negedge clk);
        inst = 32'h002081B3;
        checks++; if (ill32 !== 1'b1 || fmt32 !== FMT_ILL || imm32 !== 32'd0) begin errors++; $display("FAIL ill_op got %b/%0d/%h exp 1/%0d/0", ill32, fmt32, imm32, FMT_ILL); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (ill32 !== 1'b0 || fmt32 !== FMT_R || imm32 !== 32'd0) begin errors++; $display("FAIL add_op got %b/%0d/%h exp 0/%0d/0", ill32, fmt32, imm32, FMT_R); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; inst = 32'hFE112E23;
        @(negedge clk);
        inst = 32'h00000863;
        @(negedge clk);
        rst = 1'b1; inst = 32'h123452B7;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (vld32 !== 1'b0) begin errors++; $display("FAIL rmid_vld got %b exp 0", vld32); end
        checks++; if (imm32 !== 32'd0 || fmt32 !== FMT_R || ill32 !== 1'b0) begin errors++; $display("FAIL rmid_out got %h/%0d/%b exp 0/%0d/0", imm32, fmt32, ill32, FMT_R); end
        @(negedge clk);
        checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL rmid_rdy got %b exp 1", rdy32); end
        checks++; if (vld32 !== 1'b0) begin errors++; $display("FAIL rmid_noacc got %b exp 0", vld32); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_shift();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
